// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
// Latency: none (types, constants and a constant helper only).
// Backpressure: none; nothing in this file carries flow control.
package reg_file_pkg;

  // Clear engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clrStateT;

  localparam int DATA_W_DEF = 24;
  localparam int ADDR_W_DEF = 2;
  localparam int NUM_RD_DEF = 2;

  // Low bit index of field 'idx' in a packed bus made of fields 'width' bits wide.
  function automatic int sliceLo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear engine: on a clear request, walks every entry once, one per cycle, issuing zero writes.
// Latency: busy on the cycle after the request, DEPTH sweep cycles, then a one-cycle done pulse.
// Backpressure: none; requests arriving while sweeping or done are ignored, not queued.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clrReq,
  output logic              clrBusy,
  output logic              clrDone,
  output logic              sweepEn,
  output logic [ADDR_W-1:0] sweepAddr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clrStateT          state;
  clrStateT          stateNext;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] counterNext;

  // State and sweep counter registers; reset abandons any sweep in progress.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
    end
  end

  // Next-state logic and Moore outputs; the counter parks at the last entry when a sweep ends.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    clrBusy     = 1'b0;
    clrDone     = 1'b0;
    sweepEn     = 1'b0;
    sweepAddr   = counter;
    case (state)
      IDLE: begin
        if (clrReq) begin
          stateNext   = SWEEP;
          counterNext = '0;
        end
      end
      SWEEP: begin
        clrBusy = 1'b1;
        sweepEn = 1'b1;
        if (counter == LAST_ADDR) begin
          stateNext = DONE;
        end else begin
          counterNext = counter + ADDR_W'(1);
        end
      end
      DONE: begin
        clrDone   = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_multi.sv
// Parametrised register file: NUM_RD registered read ports, one write port, sequential clear engine.
// Latency: reads 1 cycle with same-cycle write bypass; clear takes DEPTH cycles plus one done cycle.
// Backpressure: none; external writes are silently dropped while a sweep runs. Option: REG_FILE_ZERO_REG_EN.
module reg_file_multi
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweepEn;
  logic [ADDR_W-1:0] sweepAddr;

  logic              memWrEn;
  logic [ADDR_W-1:0] memWrAddr;
  logic [DATA_W-1:0] memWrData;

  reg_file_clr_fsm #(
    .ADDR_W(ADDR_W)
  ) uClrFsm (
    .clock    (clock),
    .reset_n  (reset_n),
    .clrReq   (clr_req),
    .clrBusy  (clr_busy),
    .clrDone  (clr_done),
    .sweepEn  (sweepEn),
    .sweepAddr(sweepAddr)
  );

  // Single array write port: the sweep owns it while active, otherwise the external write.
  always_comb begin
    memWrEn   = 1'b0;
    memWrAddr = wr_addr;
    memWrData = wr_data;
    if (sweepEn) begin
      memWrEn   = 1'b1;
      memWrAddr = sweepAddr;
      memWrData = '0;
    end else if (wr_en) begin
`ifdef REG_FILE_ZERO_REG_EN
      // Entry 0 is constant zero, so external writes there go nowhere.
      memWrEn = (wr_addr != '0);
`else
      memWrEn = 1'b1;
`endif
    end
  end

  // Storage array; reset zeroes every entry and wins over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else if (memWrEn) begin
      mem[memWrAddr] <= memWrData;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    localparam int ALO = sliceLo(i, ADDR_W);
    localparam int DLO = sliceLo(i, DATA_W);

    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rNext;
    logic [DATA_W-1:0] rQ;

    assign rAddr = rd_addr[ALO +: ADDR_W];

    // Read mux: forward the value being written this cycle so the port never sees stale data.
    always_comb begin
      rNext = mem[rAddr];
      if (memWrEn && (memWrAddr == rAddr)) begin
        rNext = memWrData;
      end
`ifdef REG_FILE_ZERO_REG_EN
      if (rAddr == '0) begin
        rNext = '0;
      end
`endif
    end

    // Read output register.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        rQ <= '0;
      end else begin
        rQ <= rNext;
      end
    end

    assign rd_data[DLO +: DATA_W] = rQ;
  end

endmodule
